// File: rtl/br_credit_tx_pkg.sv
// ---------------------------------------------------------------------------
// br_credit_tx_pkg
// Shared types for the sender-side credit flow-control stage.
//   br_credit_tx_state_e : INIT (one cycle after reset, loads the credit pool)
//                          ACTIVE (normal credit spending / returning)
// ---------------------------------------------------------------------------
package br_credit_tx_pkg;

    typedef enum logic {
        INIT   = 1'b0,
        ACTIVE = 1'b1
    } br_credit_tx_state_e;

endpackage

// File: rtl/br_credit_tx_pool.sv
// ---------------------------------------------------------------------------
// br_credit_tx_pool
// Credit pool of the sender: registers the returned credit pulse, keeps the
// credit count, and derives how many credits are usable this cycle.
//
// Ports:
//   clk        in   clock (posedge)
//   rst_n      in   asynchronous active-low reset
//   load       in   INIT cycle: count loads load_value, available forced to 0
//   load_value in   credits loaded on the INIT cycle
//   ret        in   one-credit return pulse (registered before use)
//   spend      in   one credit consumed this cycle (a flit was sent)
//   withhold   in   credits kept out of circulation
//   count      out  current pool, excluding the registered return
//   available  out  usable credits this cycle
// ---------------------------------------------------------------------------
module br_credit_tx_pool
    import br_credit_tx_pkg::*;
#(
    parameter int MaxCredit            = 1,
    parameter bit EnableOverflowAssert = 1'b1,
    localparam int CountWidth          = $clog2(MaxCredit + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [CountWidth-1:0] load_value,
    input  logic                  ret,
    input  logic                  spend,
    input  logic [CountWidth-1:0] withhold,
    output logic [CountWidth-1:0] count,
    output logic [CountWidth-1:0] available
);

    localparam logic [CountWidth:0] MaxExt = (CountWidth + 1)'(MaxCredit);

    logic                  r_ret;
    logic [CountWidth-1:0] r_count;
    logic [CountWidth:0]   w_sum;
    logic [CountWidth:0]   w_withhold_ext;
    logic [CountWidth:0]   w_next_raw;
    logic [CountWidth:0]   w_diff;
    logic                  w_overflow;

    // Clamp a one-bit-wider credit quantity back into the pool range.
    function automatic logic [CountWidth-1:0] sat_credit(input logic [CountWidth:0] v);
        if (v > MaxExt) begin
            sat_credit = MaxExt[CountWidth-1:0];
        end else begin
            sat_credit = v[CountWidth-1:0];
        end
    endfunction

    // Extra bit so count + registered return never wraps.
    assign w_sum          = {1'b0, r_count} + {{CountWidth{1'b0}}, r_ret};
    assign w_withhold_ext = {1'b0, withhold};
    assign w_diff         = w_sum - w_withhold_ext;
    // A send is only possible with at least one usable credit, so this
    // subtraction never underflows.
    assign w_next_raw     = w_sum - {{CountWidth{1'b0}}, spend};
    assign w_overflow     = !load && (w_next_raw > MaxExt);

    always_comb begin
        available = '0;
        if (!load && (w_sum > w_withhold_ext)) begin
            available = sat_credit(w_diff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret   <= 1'b0;
            r_count <= '0;
        end else begin
            r_ret <= ret;
            if (load) begin
                r_count <= load_value;
            end else begin
                r_count <= sat_credit(w_next_raw);
            end
        end
    end

    assign count = r_count;

    // Integration checks on the environment around this stage.
    always @(posedge clk) begin
        if (rst_n) begin
            if (load) begin
                assert ({1'b0, load_value} <= MaxExt);
            end
            assert (w_withhold_ext <= MaxExt);
            assert (!(EnableOverflowAssert && w_overflow));
        end
    end

endmodule

// File: rtl/br_credit_tx.sv
// ---------------------------------------------------------------------------
// br_credit_tx
// Sender-side credit flow-control stage. Accepts flits from a valid/ready
// producer and drives them onto a credit-based link (valid + data, no ready).
// One credit is spent per flit sent; one is regained per pop_credit pulse.
//
// Ports:
//   clk              in   clock (posedge)
//   rst_n            in   asynchronous active-low reset
//   push_valid       in   upstream flit valid
//   push_ready       out  upstream flit accepted (independent of push_valid)
//   push_data        in   upstream flit payload
//   pop_valid        out  link flit valid, one cycle after the send
//   pop_data         out  link flit payload, held between sends
//   pop_credit       in   one-credit return pulse from the receiver
//   credit_stall     in   blocks new sends; credits still accumulate
//   credit_initial   in   credit pool loaded on the INIT cycle
//   credit_withhold  in   credits kept out of circulation
//   credit_count     out  current pool, excluding the same-cycle return
//   credit_available out  usable credits this cycle
// ---------------------------------------------------------------------------
module br_credit_tx
    import br_credit_tx_pkg::*;
#(
    parameter int Width                = 1,
    parameter int MaxCredit            = 1,
    parameter bit EnableOverflowAssert = 1'b1,
    localparam int CountWidth          = $clog2(MaxCredit + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [Width-1:0]      push_data,
    output logic                  pop_valid,
    output logic [Width-1:0]      pop_data,
    input  logic                  pop_credit,
    input  logic                  credit_stall,
    input  logic [CountWidth-1:0] credit_initial,
    input  logic [CountWidth-1:0] credit_withhold,
    output logic [CountWidth-1:0] credit_count,
    output logic [CountWidth-1:0] credit_available
);

    br_credit_tx_state_e r_state;
    br_credit_tx_state_e w_state_next;
    logic                w_load;
    logic                w_send;
    logic                r_pop_valid;
    logic [Width-1:0]    r_pop_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // INIT lasts exactly one clocked cycle; ACTIVE is terminal until reset.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            INIT: begin
                w_load       = 1'b1;
                w_state_next = ACTIVE;
            end
            ACTIVE: begin
                w_state_next = ACTIVE;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    br_credit_tx_pool #(
        .MaxCredit            (MaxCredit),
        .EnableOverflowAssert (EnableOverflowAssert)
    ) u_pool (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_value (credit_initial),
        .ret        (pop_credit),
        .spend      (w_send),
        .withhold   (credit_withhold),
        .count      (credit_count),
        .available  (credit_available)
    );

    // available is already forced to 0 in INIT; the state term keeps
    // push_ready low there regardless of pool internals.
    assign push_ready = (r_state == ACTIVE) && !credit_stall && (credit_available != '0);
    assign w_send     = push_valid && push_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
        end else begin
            r_pop_valid <= w_send;
            if (w_send) begin
                r_pop_data <= push_data;
            end
        end
    end

    assign pop_valid = r_pop_valid;
    assign pop_data  = r_pop_data;

endmodule

// File: tb/tb_br_credit_tx.sv
// ---------------------------------------------------------------------------
// tb_br_credit_tx
// Self-checking bench for br_credit_tx (Width=8, MaxCredit=4). A credit-pool
// reference model (plain integers) is advanced once per clock and every
// cycle's outputs are compared against it; directed sequences and a
// withhold/stall vector table add explicit expectations on top.
// ---------------------------------------------------------------------------
module tb_br_credit_tx;

    localparam int Width     = 8;
    localparam int MaxCredit = 4;
    localparam int CW        = $clog2(MaxCredit + 1);

    logic          clk;
    logic          rst_n;
    logic          push_valid;
    logic          push_ready;
    logic [Width-1:0] push_data;
    logic          pop_valid;
    logic [Width-1:0] pop_data;
    logic          pop_credit;
    logic          credit_stall;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic [CW-1:0] credit_available;

    br_credit_tx #(
        .Width                (Width),
        .MaxCredit            (MaxCredit),
        .EnableOverflowAssert (1'b0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_data        (push_data),
        .pop_valid        (pop_valid),
        .pop_data         (pop_data),
        .pop_credit       (pop_credit),
        .credit_stall     (credit_stall),
        .credit_initial   (credit_initial),
        .credit_withhold  (credit_withhold),
        .credit_count     (credit_count),
        .credit_available (credit_available)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_count;
    int m_ret;
    int m_pop_data;
    bit m_active;
    bit m_pop_valid;

    typedef struct {
        int withhold;
        bit stall;
        int exp_avail;
        bit exp_ready;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count     = 0;
        m_ret       = 0;
        m_pop_data  = 0;
        m_active    = 0;
        m_pop_valid = 0;
    endtask

    // Called just after a rising edge with inputs already driven: compares
    // all outputs to the model, then advances model and DUT one clock.
    task automatic step();
        int sum;
        int avail;
        bit rdy;
        bit snd;
        #1;
        sum   = m_count + m_ret;
        avail = 0;
        if (m_active && sum > int'(credit_withhold)) avail = sum - int'(credit_withhold);
        if (avail > MaxCredit) avail = MaxCredit;
        rdy = m_active && !credit_stall && (avail >= 1);
        snd = rdy && push_valid;
        chk("credit_count", credit_count, m_count);
        chk("credit_available", credit_available, avail);
        chk("push_ready", push_ready, rdy);
        chk("pop_valid", pop_valid, m_pop_valid);
        chk("pop_data", pop_data, m_pop_data);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (!m_active) begin
                m_count  = int'(credit_initial);
                m_active = 1;
            end else begin
                m_count = sum - int'(snd);
                if (m_count > MaxCredit) m_count = MaxCredit;
            end
            m_ret       = int'(pop_credit);
            m_pop_valid = snd;
            if (snd) m_pop_data = int'(push_data);
        end
    endtask

    initial begin
        int pops;

        tbl[0] = '{withhold: 3, stall: 1'b0, exp_avail: 0, exp_ready: 1'b0};
        tbl[1] = '{withhold: 1, stall: 1'b0, exp_avail: 2, exp_ready: 1'b1};
        tbl[2] = '{withhold: 0, stall: 1'b0, exp_avail: 3, exp_ready: 1'b1};
        tbl[3] = '{withhold: 4, stall: 1'b0, exp_avail: 0, exp_ready: 1'b0};
        tbl[4] = '{withhold: 2, stall: 1'b1, exp_avail: 1, exp_ready: 1'b0};
        tbl[5] = '{withhold: 0, stall: 1'b1, exp_avail: 3, exp_ready: 1'b0};

        model_reset();
        rst_n           = 1'b0;
        push_valid      = 1'b1;
        push_data       = 8'hA1;
        pop_credit      = 1'b0;
        credit_stall    = 1'b0;
        credit_initial  = 3'd2;
        credit_withhold = 3'd0;

        // Reset state, then reset exit with two credits and a waiting producer
        @(posedge clk);
        #1;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("ready_in_init", push_ready, 0);
        step();
        chk("count_after_init", credit_count, 2);
        step();
        chk("first_pop_valid", pop_valid, 1);
        chk("first_pop_data", pop_data, 8'hA1);
        push_data = 8'hA2;
        step();
        chk("second_pop_valid", pop_valid, 1);
        chk("second_pop_data", pop_data, 8'hA2);
        chk("count_drained", credit_count, 0);
        chk("ready_when_empty", push_ready, 0);
        push_valid = 1'b0;
        step();

        // Credit return from empty: usable the next cycle
        pop_credit = 1'b1;
        step();
        pop_credit = 1'b0;
        #1;
        chk("ret_ready", push_ready, 1);
        chk("ret_available", credit_available, 1);
        push_valid = 1'b1;
        push_data  = 8'h33;
        step();
        chk("ret_send_count", credit_count, 0);
        chk("ret_send_data", pop_data, 8'h33);
        push_valid = 1'b0;
        pop_credit = 1'b1;
        step();
        pop_credit = 1'b0;
        step();
        chk("ret_nosend_count", credit_count, 1);
        pop_credit = 1'b1;
        step();
        pop_credit = 1'b0;
        step();
        chk("count_two", credit_count, 2);

        // Simultaneous return and send for 10 cycles
        pop_credit = 1'b1;
        step();
        push_valid = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            push_data = 8'($urandom);
            step();
            if (pop_valid) pops++;
            chk("sim_count", credit_count, 2);
        end
        chk("sim_pops", pops, 10);
        push_valid = 1'b0;
        pop_credit = 1'b0;
        step();
        chk("count_three", credit_count, 3);

        // Withhold / stall combinational vectors at credit_count=3
        for (int i = 0; i < 6; i++) begin
            credit_withhold = CW'(tbl[i].withhold);
            credit_stall    = tbl[i].stall;
            #1;
            chk("vec_available", credit_available, tbl[i].exp_avail);
            chk("vec_ready", push_ready, tbl[i].exp_ready);
        end
        credit_withhold = 3'd0;

        // Stall blocks sends while returns still accumulate
        credit_stall = 1'b1;
        push_valid   = 1'b1;
        pop_credit   = 1'b1;
        step();
        pop_credit = 1'b0;
        step();
        chk("stall_count", credit_count, 4);
        chk("stall_ready", push_ready, 0);
        chk("stall_no_pop", pop_valid, 0);

        // Overflow: pool full, one more return saturates
        pop_credit = 1'b1;
        step();
        pop_credit = 1'b0;
        #1;
        chk("overflow_flag", dut.u_pool.w_overflow, 1);
        step();
        chk("overflow_count", credit_count, 4);
        chk("overflow_flag_clear", dut.u_pool.w_overflow, 0);

        // Mid-operation reset with a flit in the pop register
        credit_stall = 1'b0;
        push_data    = 8'h5C;
        step();
        chk("pre_reset_pop", pop_valid, 1);
        chk("pre_reset_count", credit_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pop_valid", pop_valid, 0);
        chk("async_count", credit_count, 0);
        chk("async_pop_data", pop_data, 0);
        chk("async_ready", push_ready, 0);
        model_reset();
        credit_initial = 3'd3;
        pop_credit     = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step();
        pop_credit = 1'b0;
        rst_n      = 1'b1;
        step();
        chk("reinit_count", credit_count, 3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            push_valid      = 1'($urandom);
            push_data       = 8'($urandom);
            pop_credit      = ($urandom_range(0, 2) == 0);
            credit_stall    = ($urandom_range(0, 7) == 0);
            credit_withhold = CW'($urandom_range(0, 2));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
